// File: rtl/axi4_arb_pkg.sv
// axi4_arb_pkg: shared types and constants for the two-master AXI4 arbiter.
//   rd_state_e / wr_state_e : read and write path FSM state encodings
//   *_W_DEF                 : default bus widths used by axi4_arbiter2
//   AXI_RESP_OKAY           : AXI OKAY response code
package axi4_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 64;
    localparam int unsigned ID_W_DEF   = 4;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } wr_state_e;

endpackage

// File: rtl/axi4_arb_pick.sv
// axi4_arb_pick: 2-way grant picker.
//   req[1:0] : request lines from m0 (bit 0) and m1 (bit 1)
//   grant    : index of the winning master
// With AXI4_ARB_RR_EN defined the picker keeps a last-grant pointer
// (clk, rst, update ports exist only then) and alternates on contention;
// otherwise m0 wins every contention and no state is built.
module axi4_arb_pick (
    input  logic [1:0] req,
`ifdef AXI4_ARB_RR_EN
    input  logic       clk,
    input  logic       rst,
    input  logic       update,
`endif
    output logic       grant
);

`ifdef AXI4_ARB_RR_EN
    logic last;

    // Pointer starts at m1 so that m0 wins the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (update) begin
            last <= grant;
        end
    end

    always_comb begin
        if (req == 2'b11) begin
            grant = ~last;
        end else begin
            grant = req[1];
        end
    end
`else
    always_comb begin
        grant = req[1] & ~req[0];
    end
`endif

endmodule

// File: rtl/axi4_arbiter2.sv
// axi4_arbiter2: two-master (m0 = IFU, m1 = LSU) to one-slave AXI4 arbiter.
// Read and write paths are arbitrated independently; each path owns the
// downstream port for one whole transaction and routes responses back by a
// registered owner bit. All ready/valid/payload paths are combinational.
//   clk, rst          : clock, asynchronous active-high reset
//   m0_*/m1_*         : upstream AR, R, AW, W, B channels
//   out_*             : downstream AR, R, AW, W, B channels
// Build option: AXI4_ARB_RR_EN selects round-robin (else fixed m0 priority).
module axi4_arbiter2
    import axi4_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ID_W   = ID_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    // master 0
    input  logic                m0_arvalid,
    output logic                m0_arready,
    input  logic [ID_W-1:0]     m0_arid,
    input  logic [ADDR_W-1:0]   m0_araddr,
    input  logic [7:0]          m0_arlen,
    input  logic [2:0]          m0_arsize,
    input  logic [1:0]          m0_arburst,
    output logic                m0_rvalid,
    input  logic                m0_rready,
    output logic [ID_W-1:0]     m0_rid,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic [1:0]          m0_rresp,
    output logic                m0_rlast,
    input  logic                m0_awvalid,
    output logic                m0_awready,
    input  logic [ID_W-1:0]     m0_awid,
    input  logic [ADDR_W-1:0]   m0_awaddr,
    input  logic [7:0]          m0_awlen,
    input  logic [2:0]          m0_awsize,
    input  logic [1:0]          m0_awburst,
    input  logic                m0_wvalid,
    output logic                m0_wready,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    input  logic                m0_wlast,
    output logic                m0_bvalid,
    input  logic                m0_bready,
    output logic [ID_W-1:0]     m0_bid,
    output logic [1:0]          m0_bresp,
    // master 1
    input  logic                m1_arvalid,
    output logic                m1_arready,
    input  logic [ID_W-1:0]     m1_arid,
    input  logic [ADDR_W-1:0]   m1_araddr,
    input  logic [7:0]          m1_arlen,
    input  logic [2:0]          m1_arsize,
    input  logic [1:0]          m1_arburst,
    output logic                m1_rvalid,
    input  logic                m1_rready,
    output logic [ID_W-1:0]     m1_rid,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [1:0]          m1_rresp,
    output logic                m1_rlast,
    input  logic                m1_awvalid,
    output logic                m1_awready,
    input  logic [ID_W-1:0]     m1_awid,
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic [7:0]          m1_awlen,
    input  logic [2:0]          m1_awsize,
    input  logic [1:0]          m1_awburst,
    input  logic                m1_wvalid,
    output logic                m1_wready,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic                m1_wlast,
    output logic                m1_bvalid,
    input  logic                m1_bready,
    output logic [ID_W-1:0]     m1_bid,
    output logic [1:0]          m1_bresp,
    // downstream slave port
    output logic                out_arvalid,
    input  logic                out_arready,
    output logic [ID_W-1:0]     out_arid,
    output logic [ADDR_W-1:0]   out_araddr,
    output logic [7:0]          out_arlen,
    output logic [2:0]          out_arsize,
    output logic [1:0]          out_arburst,
    input  logic                out_rvalid,
    output logic                out_rready,
    input  logic [ID_W-1:0]     out_rid,
    input  logic [DATA_W-1:0]   out_rdata,
    input  logic [1:0]          out_rresp,
    input  logic                out_rlast,
    output logic                out_awvalid,
    input  logic                out_awready,
    output logic [ID_W-1:0]     out_awid,
    output logic [ADDR_W-1:0]   out_awaddr,
    output logic [7:0]          out_awlen,
    output logic [2:0]          out_awsize,
    output logic [1:0]          out_awburst,
    output logic                out_wvalid,
    input  logic                out_wready,
    output logic [DATA_W-1:0]   out_wdata,
    output logic [DATA_W/8-1:0] out_wstrb,
    output logic                out_wlast,
    input  logic                out_bvalid,
    output logic                out_bready,
    input  logic [ID_W-1:0]     out_bid,
    input  logic [1:0]          out_bresp
);

    rd_state_e rd_state;
    wr_state_e wr_state;
    logic      rd_owner, wr_owner;
    logic      rd_grant, wr_grant;
    logic [1:0] rd_req, wr_req;

    assign rd_req = {m1_arvalid, m0_arvalid};
    assign wr_req = {m1_awvalid, m0_awvalid};

    axi4_arb_pick u_rd_pick (
        .req    (rd_req),
`ifdef AXI4_ARB_RR_EN
        .clk    (clk),
        .rst    (rst),
        .update (rd_state == R_IDLE && (|rd_req)),
`endif
        .grant  (rd_grant)
    );

    axi4_arb_pick u_wr_pick (
        .req    (wr_req),
`ifdef AXI4_ARB_RR_EN
        .clk    (clk),
        .rst    (rst),
        .update (wr_state == W_IDLE && (|wr_req)),
`endif
        .grant  (wr_grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state <= R_IDLE;
            rd_owner <= 1'b0;
        end else begin
            case (rd_state)
                R_IDLE: if (|rd_req) begin
                    rd_owner <= rd_grant;
                    rd_state <= R_ADDR;
                end
                R_ADDR: if (out_arvalid && out_arready) rd_state <= R_DATA;
                R_DATA: if (out_rvalid && out_rready && out_rlast) rd_state <= R_IDLE;
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state <= W_IDLE;
            wr_owner <= 1'b0;
        end else begin
            case (wr_state)
                W_IDLE: if (|wr_req) begin
                    wr_owner <= wr_grant;
                    wr_state <= W_ADDR;
                end
                W_ADDR: if (out_awvalid && out_awready) wr_state <= W_DATA;
                W_DATA: if (out_wvalid && out_wready && out_wlast) wr_state <= W_RESP;
                W_RESP: if (out_bvalid && out_bready) wr_state <= W_IDLE;
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // Read path mux: everything not selected by state/owner stays 0.
    always_comb begin
        out_arvalid = 1'b0; out_arid = '0; out_araddr = '0;
        out_arlen = '0; out_arsize = '0; out_arburst = '0;
        m0_arready = 1'b0; m1_arready = 1'b0;
        out_rready = 1'b0;
        m0_rvalid = 1'b0; m0_rid = '0; m0_rdata = '0; m0_rresp = '0; m0_rlast = 1'b0;
        m1_rvalid = 1'b0; m1_rid = '0; m1_rdata = '0; m1_rresp = '0; m1_rlast = 1'b0;
        if (rd_state == R_ADDR) begin
            if (rd_owner) begin
                out_arvalid = m1_arvalid; out_arid = m1_arid; out_araddr = m1_araddr;
                out_arlen = m1_arlen; out_arsize = m1_arsize; out_arburst = m1_arburst;
                m1_arready = out_arready;
            end else begin
                out_arvalid = m0_arvalid; out_arid = m0_arid; out_araddr = m0_araddr;
                out_arlen = m0_arlen; out_arsize = m0_arsize; out_arburst = m0_arburst;
                m0_arready = out_arready;
            end
        end
        if (rd_state == R_DATA) begin
            if (rd_owner) begin
                m1_rvalid = out_rvalid; m1_rid = out_rid; m1_rdata = out_rdata;
                m1_rresp = out_rresp; m1_rlast = out_rlast;
                out_rready = m1_rready;
            end else begin
                m0_rvalid = out_rvalid; m0_rid = out_rid; m0_rdata = out_rdata;
                m0_rresp = out_rresp; m0_rlast = out_rlast;
                out_rready = m0_rready;
            end
        end
    end

    // Write path mux: W is only forwarded in W_DATA, so early W stalls.
    always_comb begin
        out_awvalid = 1'b0; out_awid = '0; out_awaddr = '0;
        out_awlen = '0; out_awsize = '0; out_awburst = '0;
        m0_awready = 1'b0; m1_awready = 1'b0;
        out_wvalid = 1'b0; out_wdata = '0; out_wstrb = '0; out_wlast = 1'b0;
        m0_wready = 1'b0; m1_wready = 1'b0;
        out_bready = 1'b0;
        m0_bvalid = 1'b0; m0_bid = '0; m0_bresp = '0;
        m1_bvalid = 1'b0; m1_bid = '0; m1_bresp = '0;
        case (wr_state)
            W_ADDR: begin
                if (wr_owner) begin
                    out_awvalid = m1_awvalid; out_awid = m1_awid; out_awaddr = m1_awaddr;
                    out_awlen = m1_awlen; out_awsize = m1_awsize; out_awburst = m1_awburst;
                    m1_awready = out_awready;
                end else begin
                    out_awvalid = m0_awvalid; out_awid = m0_awid; out_awaddr = m0_awaddr;
                    out_awlen = m0_awlen; out_awsize = m0_awsize; out_awburst = m0_awburst;
                    m0_awready = out_awready;
                end
            end
            W_DATA: begin
                if (wr_owner) begin
                    out_wvalid = m1_wvalid; out_wdata = m1_wdata;
                    out_wstrb = m1_wstrb; out_wlast = m1_wlast;
                    m1_wready = out_wready;
                end else begin
                    out_wvalid = m0_wvalid; out_wdata = m0_wdata;
                    out_wstrb = m0_wstrb; out_wlast = m0_wlast;
                    m0_wready = out_wready;
                end
            end
            W_RESP: begin
                if (wr_owner) begin
                    m1_bvalid = out_bvalid; m1_bid = out_bid; m1_bresp = out_bresp;
                    out_bready = m1_bready;
                end else begin
                    m0_bvalid = out_bvalid; m0_bid = out_bid; m0_bresp = out_bresp;
                    out_bready = m0_bready;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi4_arbiter2.sv
// tb_axi4_arbiter2: directed self-checking bench for axi4_arbiter2.
module tb_axi4_arbiter2;
    import axi4_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
    logic [3:0]  m0_arid, m0_rid, m0_awid, m0_bid;
    logic [31:0] m0_araddr, m0_awaddr;
    logic [7:0]  m0_arlen, m0_awlen, m0_wstrb;
    logic [2:0]  m0_arsize, m0_awsize;
    logic [1:0]  m0_arburst, m0_awburst, m0_rresp, m0_bresp;
    logic [63:0] m0_rdata, m0_wdata;
    logic        m0_awvalid, m0_awready, m0_wvalid, m0_wready, m0_wlast, m0_bvalid, m0_bready;

    logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
    logic [3:0]  m1_arid, m1_rid, m1_awid, m1_bid;
    logic [31:0] m1_araddr, m1_awaddr;
    logic [7:0]  m1_arlen, m1_awlen, m1_wstrb;
    logic [2:0]  m1_arsize, m1_awsize;
    logic [1:0]  m1_arburst, m1_awburst, m1_rresp, m1_bresp;
    logic [63:0] m1_rdata, m1_wdata;
    logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_wlast, m1_bvalid, m1_bready;

    logic        out_arvalid, out_arready, out_rvalid, out_rready, out_rlast;
    logic [3:0]  out_arid, out_rid, out_awid, out_bid;
    logic [31:0] out_araddr, out_awaddr;
    logic [7:0]  out_arlen, out_awlen, out_wstrb;
    logic [2:0]  out_arsize, out_awsize;
    logic [1:0]  out_arburst, out_awburst, out_rresp, out_bresp;
    logic [63:0] out_rdata, out_wdata;
    logic        out_awvalid, out_awready, out_wvalid, out_wready, out_wlast, out_bvalid, out_bready;

    axi4_arbiter2 #(.ADDR_W(32), .DATA_W(64), .ID_W(4)) dut (
        .clk(clk), .rst(rst),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_arid(m0_arid), .m0_araddr(m0_araddr),
        .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rid(m0_rid), .m0_rdata(m0_rdata),
        .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
        .m0_awvalid(m0_awvalid), .m0_awready(m0_awready), .m0_awid(m0_awid), .m0_awaddr(m0_awaddr),
        .m0_awlen(m0_awlen), .m0_awsize(m0_awsize), .m0_awburst(m0_awburst),
        .m0_wvalid(m0_wvalid), .m0_wready(m0_wready), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_wlast(m0_wlast), .m0_bvalid(m0_bvalid), .m0_bready(m0_bready), .m0_bid(m0_bid),
        .m0_bresp(m0_bresp),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_arid(m1_arid), .m1_araddr(m1_araddr),
        .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rid(m1_rid), .m1_rdata(m1_rdata),
        .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
        .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awid(m1_awid), .m1_awaddr(m1_awaddr),
        .m1_awlen(m1_awlen), .m1_awsize(m1_awsize), .m1_awburst(m1_awburst),
        .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_wlast(m1_wlast), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bid(m1_bid),
        .m1_bresp(m1_bresp),
        .out_arvalid(out_arvalid), .out_arready(out_arready), .out_arid(out_arid),
        .out_araddr(out_araddr), .out_arlen(out_arlen), .out_arsize(out_arsize),
        .out_arburst(out_arburst), .out_rvalid(out_rvalid), .out_rready(out_rready),
        .out_rid(out_rid), .out_rdata(out_rdata), .out_rresp(out_rresp), .out_rlast(out_rlast),
        .out_awvalid(out_awvalid), .out_awready(out_awready), .out_awid(out_awid),
        .out_awaddr(out_awaddr), .out_awlen(out_awlen), .out_awsize(out_awsize),
        .out_awburst(out_awburst), .out_wvalid(out_wvalid), .out_wready(out_wready),
        .out_wdata(out_wdata), .out_wstrb(out_wstrb), .out_wlast(out_wlast),
        .out_bvalid(out_bvalid), .out_bready(out_bready), .out_bid(out_bid), .out_bresp(out_bresp)
    );

    int unsigned tests = 0;
    int unsigned fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [3:0] exp_id;
    int unsigned got;
    int unsigned sent;
    logic [5:0] pat;

    initial begin
        {m0_arvalid, m0_arid, m0_araddr, m0_arlen, m0_arsize, m0_arburst, m0_rready} = '0;
        {m0_awvalid, m0_awid, m0_awaddr, m0_awlen, m0_awsize, m0_awburst} = '0;
        {m0_wvalid, m0_wdata, m0_wstrb, m0_wlast, m0_bready} = '0;
        {m1_arvalid, m1_arid, m1_araddr, m1_arlen, m1_arsize, m1_arburst, m1_rready} = '0;
        {m1_awvalid, m1_awid, m1_awaddr, m1_awlen, m1_awsize, m1_awburst} = '0;
        {m1_wvalid, m1_wdata, m1_wstrb, m1_wlast, m1_bready} = '0;
        {out_arready, out_rvalid, out_rid, out_rdata, out_rresp, out_rlast} = '0;
        {out_awready, out_wready, out_bvalid, out_bid, out_bresp} = '0;

        // Reset state: all outputs low.
        do_reset();
        #1;
        check("rst_out_arvalid", out_arvalid, 0);
        check("rst_out_awvalid", out_awvalid, 0);
        check("rst_out_wvalid", out_wvalid, 0);
        check("rst_out_rready", out_rready, 0);
        check("rst_out_bready", out_bready, 0);
        check("rst_m0_rvalid", m0_rvalid, 0);
        check("rst_m1_bvalid", m1_bvalid, 0);

        // Single m0 read, len 3.
        m0_arvalid = 1; m0_arid = 4'h5; m0_araddr = 32'h8000_0000; m0_arlen = 8'd3;
        m0_arsize = 3'd3; m0_arburst = 2'd1; m0_rready = 1; m1_rready = 1;
        #1;
        check("t1_idle_arready", m0_arready, 0);
        check("t1_idle_out_arvalid", out_arvalid, 0);
        tick();
        check("t1_out_arvalid", out_arvalid, 1);
        check("t1_out_araddr", out_araddr, 64'h8000_0000);
        check("t1_out_arlen", out_arlen, 3);
        check("t1_arready_stall", m0_arready, 0);
        out_arready = 1;
        #1;
        check("t1_m0_arready", m0_arready, 1);
        check("t1_m1_arready", m1_arready, 0);
        tick();
        m0_arvalid = 0; out_arready = 0;
        for (int i = 0; i < 4; i++) begin
            out_rvalid = 1; out_rid = 4'h5; out_rdata = 64'h100 + 64'(i); out_rlast = (i == 3);
            #1;
            check("t1_m0_rvalid", m0_rvalid, 1);
            check("t1_m0_rdata", m0_rdata, 64'h100 + 64'(i));
            check("t1_m0_rlast", m0_rlast, (i == 3));
            check("t1_m1_rvalid", m1_rvalid, 0);
            check("t1_m1_rdata", m1_rdata, 0);
            tick();
        end
        out_rvalid = 0; out_rlast = 0;
        #1;
        check("t1_back_idle_rready", out_rready, 0);

        // Contention, 4 back-to-back transactions.
        do_reset();
        m0_arvalid = 1; m0_arid = 4'h1; m1_arvalid = 1; m1_arid = 4'h2;
        for (int i = 0; i < 4; i++) begin
`ifdef AXI4_ARB_RR_EN
            exp_id = (i % 2 == 0) ? 4'h1 : 4'h2;
`else
            exp_id = 4'h1;
`endif
            tick();
            check("t2_grant_id", out_arid, exp_id);
            out_arready = 1;
            #1;
            check("t2_arready_m0", m0_arready, (exp_id == 4'h1));
            check("t2_arready_m1", m1_arready, (exp_id == 4'h2));
            tick();
            out_arready = 0; out_rvalid = 1; out_rlast = 1; out_rdata = 64'hAB;
            #1;
            check("t2_rvalid_m1", m1_rvalid, (exp_id == 4'h2));
            tick();
            out_rvalid = 0; out_rlast = 0;
        end
        m0_arvalid = 0; m1_arvalid = 0;
        tick();

        // m1 write, W presented before AW.
        m1_wvalid = 1; m1_wdata = 64'hA0; m1_wstrb = 8'hFF; m1_wlast = 0; out_wready = 1;
        m1_bready = 1; m0_bready = 1;
        #1;
        check("t3_early_wready", m1_wready, 0);
        check("t3_early_out_wvalid", out_wvalid, 0);
        tick();
        check("t3_early_wready2", m1_wready, 0);
        m1_awvalid = 1; m1_awid = 4'h3; m1_awaddr = 32'h1000; m1_awlen = 8'd1;
        tick();
        check("t3_out_awvalid", out_awvalid, 1);
        check("t3_out_awaddr", out_awaddr, 64'h1000);
        check("t3_addr_wready", m1_wready, 0);
        out_awready = 1;
        #1;
        check("t3_m1_awready", m1_awready, 1);
        tick();
        m1_awvalid = 0; out_awready = 0;
        #1;
        check("t3_w0_wready", m1_wready, 1);
        check("t3_w0_data", out_wdata, 64'hA0);
        check("t3_w0_m0_wready", m0_wready, 0);
        tick();
        m1_wdata = 64'hA1; m1_wlast = 1;
        #1;
        check("t3_w1_data", out_wdata, 64'hA1);
        check("t3_w1_last", out_wlast, 1);
        tick();
        m1_wvalid = 0; m1_wlast = 0;
        out_bvalid = 1; out_bid = 4'h3; out_bresp = AXI_RESP_OKAY;
        #1;
        check("t3_m1_bvalid", m1_bvalid, 1);
        check("t3_m1_bid", m1_bid, 3);
        check("t3_m1_bresp", m1_bresp, 0);
        check("t3_m0_bvalid", m0_bvalid, 0);
        check("t3_out_bready", out_bready, 1);
        tick();
        out_bvalid = 0;
        #1;
        check("t3_idle_bready", out_bready, 0);

        // Concurrent m0 read len 7 and m1 write len 0.
        m0_arvalid = 1; m0_arid = 4'h7; m0_arlen = 8'd7;
        m1_awvalid = 1; m1_awid = 4'h8; m1_awlen = 8'd0;
        tick();
        check("t4_ar_overlap", out_arvalid, 1);
        check("t4_aw_overlap", out_awvalid, 1);
        check("t4_awid", out_awid, 8);
        out_arready = 1; out_awready = 1;
        tick();
        m0_arvalid = 0; m1_awvalid = 0; out_arready = 0; out_awready = 0;
        for (int i = 0; i < 8; i++) begin
            out_rvalid = 1; out_rdata = 64'h700 + 64'(i); out_rlast = (i == 7);
            if (i == 0) begin
                m1_wvalid = 1; m1_wdata = 64'hC0; m1_wlast = 1; out_wready = 1;
            end
            if (i == 1) begin
                out_bvalid = 1; out_bid = 4'h8;
            end
            #1;
            check("t4_m0_rdata", m0_rdata, 64'h700 + 64'(i));
            check("t4_m1_rvalid", m1_rvalid, 0);
            if (i == 0) begin
                check("t4_m1_wready", m1_wready, 1);
                check("t4_out_wdata", out_wdata, 64'hC0);
            end
            if (i == 1) begin
                check("t4_m1_bvalid", m1_bvalid, 1);
                check("t4_m0_bvalid", m0_bvalid, 0);
            end
            tick();
            m1_wvalid = 0; m1_wlast = 0; out_bvalid = 0;
        end
        out_rvalid = 0; out_rlast = 0;
        #1;
        check("t4_rd_idle", out_rready, 0);
        check("t4_wr_idle", out_bready, 0);

        // Address stall 5 cycles, then gapped R beats.
        m0_arvalid = 1; m0_arid = 4'h4; m0_arlen = 8'd2;
        tick();
        m1_arvalid = 1; m1_arid = 4'h6;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t5_stall_id", out_arid, 4);
            check("t5_stall_m1_arready", m1_arready, 0);
            tick();
        end
        out_arready = 1;
        #1;
        check("t5_m0_arready", m0_arready, 1);
        tick();
        m0_arvalid = 0; out_arready = 0;
        pat = 6'b100101;
        got = 0; sent = 0;
        for (int i = 0; i < 6; i++) begin
            out_rvalid = pat[i];
            out_rdata = 64'h500 + 64'(sent);
            out_rlast = pat[i] && (sent == 2);
            #1;
            check("t5_m0_rvalid", m0_rvalid, pat[i]);
            check("t5_m1_rvalid", m1_rvalid, 0);
            if (m0_rvalid && m0_rready) begin
                check("t5_beat_data", m0_rdata, 64'h500 + 64'(got));
                got++;
            end
            if (pat[i]) sent++;
            tick();
        end
        out_rvalid = 0; out_rlast = 0;
        check("t5_beat_count", 64'(got), 3);
        tick();
        check("t5_next_m1", out_arid, 6);
        m1_arvalid = 0;

        // Reset during R_DATA beat 2 of 4.
        do_reset();
        m0_arvalid = 1; m0_arid = 4'h7; m0_arlen = 8'd3;
        tick();
        out_arready = 1;
        tick();
        m0_arvalid = 0; out_arready = 0;
        out_rvalid = 1; out_rdata = 64'h900;
        tick();
        out_rdata = 64'h901;
        #1;
        check("t6_pre_rvalid", m0_rvalid, 1);
        rst = 1;
        #1;
        check("t6_rst_m0_rvalid", m0_rvalid, 0);
        check("t6_rst_m0_rdata", m0_rdata, 0);
        check("t6_rst_out_rready", out_rready, 0);
        check("t6_rst_out_arvalid", out_arvalid, 0);
        out_rvalid = 0;
        tick();
        rst = 0;
        m1_arvalid = 1; m1_arid = 4'h9;
        tick();
        check("t6_m1_arvalid", out_arvalid, 1);
        check("t6_m1_grant", out_arid, 9);
        out_arready = 1;
        #1;
        check("t6_m1_arready", m1_arready, 1);
        check("t6_m0_arready", m0_arready, 0);
        tick();
        m1_arvalid = 0; out_arready = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
